// File: rtl/scan_seq_engine_if.sv
// Host bus of scan_seq_engine: table-load strobes, run control and status.
// The master side is the host; the slave side is the sequencer.
interface scan_seq_engine_if #(
  parameter int NOUT = 9
);
  logic [15:0]     datain;
  logic            scanload;
  logic            scanchoice;
  logic            load_clr;
  logic            scanstart;
  logic            scanabort;
  logic [NOUT-1:0] ctrl_out;
  logic            busy;
  logic            state_over_n;
  logic [5:0]      step_idx;
  logic            load_err;

  modport master (
    output datain, scanload, scanchoice, load_clr, scanstart, scanabort,
    input  ctrl_out, busy, state_over_n, step_idx, load_err
  );

  modport slave (
    input  datain, scanload, scanchoice, load_clr, scanstart, scanabort,
    output ctrl_out, busy, state_over_n, step_idx, load_err
  );
endinterface

// File: rtl/scan_seq_engine.sv
// Table-driven scan sequencer: two host-loaded step banks played as pattern/duration steps.
// Optional macro SCAN_REPEAT_EN honours the header repeat count (R+1 passes).
module scan_seq_engine #(
  parameter int              NOUT     = 9,
  parameter int              STEPS    = 16,
  parameter int              TW       = 20,
  parameter logic [NOUT-1:0] IDLE_PAT = '0
) (
  input logic               clk_sys,
  input logic               rst_n,
  scan_seq_engine_if.slave  bus
);

  localparam int              WORDS    = 1 + 3 * STEPS;
  localparam int              PW       = $clog2(WORDS + 1);
  localparam logic [PW-1:0]   PTR_END  = PW'(WORDS);
  localparam logic [5:0]      LAST_MAX = 6'(STEPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RUN, S_DONE} state_t;

  // Step tables, split by field so each word keeps only the bits it uses.
  logic [5:0]      hdr_last_q [2];
  logic [NOUT-1:0] pat_q      [2][STEPS];
  logic [15:0]     dlo_q      [2][STEPS];
  logic [TW-17:0]  dhi_q      [2][STEPS];
`ifdef SCAN_REPEAT_EN
  logic [7:0]      hdr_rep_q  [2];
  logic [7:0]      pass_q, pass_d;
`endif

  logic [PW-1:0]   ptr_q;
  logic            load_err_q;
  logic            wr_blocked;

  state_t          state_q, state_d;
  logic [NOUT-1:0] ctrl_q, ctrl_d;
  logic            busy_q, busy_d;
  logic            over_n_q, over_n_d;
  logic [5:0]      step_q, step_d;
  logic [5:0]      last_q, last_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic            run_bank_q, run_bank_d;

  logic [5:0]      rd_step;
  logic [NOUT-1:0] rd_pat;
  logic [TW-1:0]   rd_dur;
  logic [TW-1:0]   dur_m1;
  logic            load_step;

  assign wr_blocked = busy_q && (bus.scanchoice == run_bank_q);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      load_err_q <= 1'b0;
      // NOTE: the tables live in flops with an async clear; a RAM could not be wiped by reset.
      for (int b = 0; b < 2; b++) begin
        hdr_last_q[b] <= '0;
`ifdef SCAN_REPEAT_EN
        hdr_rep_q[b]  <= '0;
`endif
        for (int k = 0; k < STEPS; k++) begin
          pat_q[b][k] <= '0;
          dlo_q[b][k] <= '0;
          dhi_q[b][k] <= '0;
        end
      end
    end else if (bus.load_clr) begin
      ptr_q      <= '0;
      load_err_q <= 1'b0;
    end else if (bus.scanload) begin
      if (ptr_q == PTR_END || wr_blocked) begin
        load_err_q <= 1'b1;
      end else begin
        if (ptr_q == '0) begin
          hdr_last_q[bus.scanchoice] <= bus.datain[5:0];
`ifdef SCAN_REPEAT_EN
          hdr_rep_q[bus.scanchoice]  <= bus.datain[15:8];
`endif
        end
        for (int k = 0; k < STEPS; k++) begin
          if (int'(ptr_q) == 1 + 3 * k) pat_q[bus.scanchoice][k] <= bus.datain[NOUT-1:0];
          if (int'(ptr_q) == 2 + 3 * k) dlo_q[bus.scanchoice][k] <= bus.datain;
          if (int'(ptr_q) == 3 + 3 * k) dhi_q[bus.scanchoice][k] <= bus.datain[TW-17:0];
        end
      end
      if (ptr_q != PTR_END) ptr_q <= ptr_q + PW'(1);
    end
  end

  // The step about to be entered: 0 from FETCH or on a pass wrap, else the successor.
  always_comb begin
    rd_step = '0;
    if (state_q == S_RUN && step_q != last_q) rd_step = step_q + 6'd1;
  end

  always_comb begin
    rd_pat = '0;
    rd_dur = '0;
    for (int k = 0; k < STEPS; k++) begin
      if (int'(rd_step) == k) begin
        rd_pat = pat_q[run_bank_q][k];
        rd_dur = {dhi_q[run_bank_q][k], dlo_q[run_bank_q][k]};
      end
    end
  end

  assign dur_m1 = (rd_dur == '0) ? '0 : rd_dur - TW'(1);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ctrl_q     <= IDLE_PAT;
      busy_q     <= 1'b0;
      over_n_q   <= 1'b1;
      step_q     <= '0;
      last_q     <= '0;
      cnt_q      <= '0;
      run_bank_q <= 1'b0;
`ifdef SCAN_REPEAT_EN
      pass_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      busy_q     <= busy_d;
      over_n_q   <= over_n_d;
      step_q     <= step_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      run_bank_q <= run_bank_d;
`ifdef SCAN_REPEAT_EN
      pass_q     <= pass_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    busy_d     = busy_q;
    over_n_d   = 1'b1;
    step_d     = step_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    run_bank_d = run_bank_q;
    load_step  = 1'b0;
`ifdef SCAN_REPEAT_EN
    pass_d     = pass_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // busy_q may still be high for the one-cycle tail after DONE.
        busy_d = 1'b0;
        if (bus.scanstart && !busy_q) begin
          state_d    = S_FETCH;
          run_bank_d = bus.scanchoice;
          busy_d     = 1'b1;
        end
      end
      S_FETCH: begin
        last_d    = (hdr_last_q[run_bank_q] > LAST_MAX) ? LAST_MAX : hdr_last_q[run_bank_q];
        step_d    = '0;
        load_step = 1'b1;
        state_d   = S_RUN;
`ifdef SCAN_REPEAT_EN
        pass_d    = '0;
`endif
      end
      S_RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - TW'(1);
        end else if (step_q != last_q) begin
          step_d    = step_q + 6'd1;
          load_step = 1'b1;
`ifdef SCAN_REPEAT_EN
        end else if (pass_q < hdr_rep_q[run_bank_q]) begin
          pass_d    = pass_q + 8'd1;
          step_d    = '0;
          load_step = 1'b1;
`endif
        end else begin
          state_d  = S_DONE;
          ctrl_d   = IDLE_PAT;
          over_n_d = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase

    if (load_step) begin
      ctrl_d = rd_pat;
      cnt_d  = dur_m1;
    end

    if (bus.scanabort) begin
      state_d  = S_IDLE;
      ctrl_d   = IDLE_PAT;
      over_n_d = 1'b1;
      busy_d   = 1'b0;
    end
  end

  assign bus.ctrl_out     = ctrl_q;
  assign bus.busy         = busy_q;
  assign bus.state_over_n = over_n_q;
  assign bus.step_idx     = step_q;
  assign bus.load_err     = load_err_q;

endmodule

// File: doc/scan_seq_engine.md
# scan_seq_engine

Programmable, table-driven scan sequencer: a parametrised successor to the fixed scan state machine plus per-state timer pair. Host firmware loads two banks of step tables over the 16-bit bus. Each step holds an NOUT-bit control pattern (dump, switch, acquisition, DDS and calibration lines) and a TW-bit duration. On `scanstart` the engine plays the selected bank, optionally repeated, and then signals completion with the active-low `state_over_n`.

## Interface
Parameters:
- NOUT, 9: number of control outputs (1..16)
- STEPS, 16: steps per bank (2..64)
- TW, 20: duration width (17..32)
- IDLE_PAT, 0: NOUT-bit pattern driven when not running

Ports:
- clk_sys  in  1  system clock, single clock domain
- rst_n  in  1  asynchronous active-low reset
- datain  in  16  load data word
- scanload  in  1  one-cycle write strobe for `datain`
- scanchoice  in  1  bank select; used for loads and latched at start
- load_clr  in  1  clears load pointer and `load_err`
- scanstart  in  1  start pulse
- scanabort  in  1  abort pulse
- ctrl_out  out  NOUT  registered control pattern
- busy  out  1  sequence active (FETCH/RUN/DONE)
- state_over_n  out  1  low for exactly one cycle at normal completion
- step_idx  out  6  current step index
- load_err  out  1  sticky load error

## Operation
- Bank layout: 1+3·STEPS words.
  - Word 0 is the header: [5:0] last step index L, [15:8] repeat count R.
  - Step k occupies words 1+3k .. 3+3k: pattern (low NOUT bits), dur_lo, dur_hi (low TW-16 bits).
- Load path:
  - Each `scanload` writes `datain` at the load pointer into bank `scanchoice`, then increments the pointer.
  - Pointer past 3·STEPS, or a write to the bank currently running: the write is dropped and `load_err` is set.
  - `load_clr` takes priority over a simultaneous `scanload`.
- States:
  - IDLE: on `scanstart` latch `scanchoice` as run bank, go to FETCH.
  - FETCH: read header, clamp L to STEPS-1, step=0, pass=0, go to RUN.
  - RUN: drive pattern[step] for D = max(dur,1) cycles. At the end, advance to the next step. After step L:
    - if pass < R (repeat enabled), set pass+1, step=0;
    - otherwise go to DONE.
  - DONE: `ctrl_out`=IDLE_PAT, `state_over_n`=0, then go to IDLE.
- `scanstart` while busy: ignored.
- `scanabort`: from any busy state, go to IDLE at the next edge with `ctrl_out`=IDLE_PAT. `state_over_n` stays high. Abort wins over a simultaneous start.
- Duration: {dur_hi[TW-17:0], dur_lo}, unsigned. A down-counter is loaded with D-1 at step entry.

## Timing
- Reset values:
  - `ctrl_out`=IDLE_PAT, `busy`=0, `state_over_n`=1, `step_idx`=0, `load_err`=0, load pointer 0.
  - All table words 0, so an empty bank plays one 1-cycle step of pattern 0.
- `scanstart` sampled at edge t: FETCH during t..t+1; `ctrl_out`=pattern0 from edge t+1.
- Step boundaries are exact: the pattern changes on the edge after D cycles, with no gap cycle between steps or passes.
- DONE lasts one cycle directly after the last step. `busy` falls one cycle after `state_over_n` returns high.
- Reset asserted mid-run: all outputs return to their reset values immediately and the tables are cleared.

## Configuration
- SCAN_REPEAT_EN defined: header R is honoured; the sequence plays R+1 passes (R=0 means once).
- SCAN_REPEAT_EN undefined: header bits [15:8] are ignored, exactly one pass, and the pass counter is not built.

## Test plan
- Load bank0 with L=2, patterns 0x001/0x002/0x004, durations 3/1/5, then start → `ctrl_out` 0x001×3, 0x002×1, 0x004×5; `state_over_n` low in the next cycle; total 1+9+1 cycles.
- Duration 0 step and duration 0xFFFFF (TW=20) → the 0 step lasts 1 cycle; the large step lasts 1048575 cycles, checked via counter peek or a shortened run.
- With SCAN_REPEAT_EN, R=2, L=1 → 3 seamless passes, `step_idx` 0,1,0,1,0,1, single `state_over_n` pulse.
- Running bank0 while loading bank1 succeeds; a write to bank0 while running sets `load_err`; the 3·STEPS+2-th write sets `load_err`; `load_clr` clears it.
- `scanabort` mid step 1 → next edge `ctrl_out`=IDLE_PAT, `busy`=0, no `state_over_n` pulse. `scanstart` during RUN is ignored.
- `rst_n` low during RUN → outputs at reset values asynchronously; after release, start plays a zero table (pattern 0, 1 cycle).
